// File: rtl/soc_bus_pkg.sv
// -----------------------------------------------------------------------------
// soc_bus_pkg
// Shared definitions for the SoC bus fabric: the fabric FSM state encoding and
// the default pattern returned as read data on any errored access.
// -----------------------------------------------------------------------------
package soc_bus_pkg;

    // Fabric FSM states; the encoding is fixed so that debug probes can read it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_e;

    // Read data returned when an access is unmapped or abandoned.
    localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

endpackage : soc_bus_pkg

// File: rtl/soc_bus_decode.sv
// -----------------------------------------------------------------------------
// soc_bus_decode
// Combinational slave-select decoder. It compares the select field of the
// master address against the code of every slave. If several slaves share a
// code, the lowest index wins, so the hit vector is always one-hot or zero.
//
// Ports:
//   i_sel      select field taken from the master address
//   o_hit_vec  one-hot vector of the winning slave (all zero on a miss)
//   o_hit      at least one slave matched
// -----------------------------------------------------------------------------
module soc_bus_decode #(
    parameter int                       NUM_SLV = 3,
    parameter int                       SEL_W   = 4,
    parameter logic [NUM_SLV*SEL_W-1:0] SLV_SEL = {4'h6, 4'h4, 4'h0}
) (
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_SLV-1:0] o_hit_vec,
    output logic               o_hit
);

    logic [NUM_SLV-1:0] w_match;

    // Raw match of the select field against every slave code.
    always_comb begin
        w_match = {NUM_SLV{1'b0}};
        for (int k = 0; k < NUM_SLV; k++) begin
            w_match[k] = (i_sel == SLV_SEL[k*SEL_W +: SEL_W]);
        end
    end

    // Isolating the lowest set bit gives the lowest-index winner.
    assign o_hit_vec = w_match & (~w_match + NUM_SLV'(1));
    assign o_hit     = |w_match;

endmodule : soc_bus_decode

// File: rtl/soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// soc_bus_fabric
// Registered request/acknowledge interconnect between the MIPS core data port
// and NUM_SLV memory-mapped slaves. A request is accepted only in IDLE. A hit
// holds a one-hot s_req until the addressed slave acks. A miss answers straight
// away with an error. Every master-side output comes from a register.
//
// Configuration macro:
//   SOC_BUS_TIMEOUT_EN  When defined, an access with no ack within TIMEOUT_CYC
//                       cycles is abandoned and answered with an error.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   m_req/m_we        master request strobe (sampled in IDLE) and write flag
//   m_addr/m_wdata    master byte address and write data
//   m_rdata           registered read data
//   m_ready/m_err     one-cycle response strobe and its error flag
//   s_req             one-hot slave request, held until ack
//   s_we/s_addr       latched write flag and low address bits
//   s_wdata           latched write data
//   s_rdata           flat slave read data, slave k at [k*DATA_W +: DATA_W]
//   s_ack             per-slave completion (may be combinational from s_req)
// -----------------------------------------------------------------------------
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                       NUM_SLV     = 3,
    parameter int                       DATA_W      = 32,
    parameter int                       ADDR_W      = 32,
    parameter int                       SEL_LSB     = 9,
    parameter int                       SEL_W       = 4,
    parameter logic [NUM_SLV*SEL_W-1:0] SLV_SEL     = {4'h6, 4'h4, 4'h0},
    parameter int                       TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0]        ERR_DATA    = DATA_W'(ERR_DATA_DFLT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic [NUM_SLV-1:0]        s_req,
    output logic                      s_we,
    output logic [SEL_LSB-1:0]        s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ack
);

    bus_state_e r_state;
    bus_state_e w_state_nxt;

    logic [NUM_SLV-1:0] r_s_req;
    logic               r_s_we;
    logic [SEL_LSB-1:0] r_s_addr;
    logic [DATA_W-1:0]  r_s_wdata;
    logic [DATA_W-1:0]  r_m_rdata;
    logic               r_m_ready;
    logic               r_m_err;

    logic [NUM_SLV-1:0] w_s_req_nxt;
    logic               w_s_we_nxt;
    logic [SEL_LSB-1:0] w_s_addr_nxt;
    logic [DATA_W-1:0]  w_s_wdata_nxt;
    logic [DATA_W-1:0]  w_rdata_nxt;
    logic               w_ready_nxt;
    logic               w_err_nxt;

    logic [SEL_W-1:0]   w_dec_sel;
    logic [NUM_SLV-1:0] w_dec_vec;
    logic               w_dec_hit;
    logic               w_ack_hit;
    logic               w_tmo_expire;
    logic [DATA_W-1:0]  w_sel_rdata;
    logic               w_unused;

    assign w_dec_sel = m_addr[SEL_LSB+SEL_W-1:SEL_LSB];

    soc_bus_decode #(
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W),
        .SLV_SEL (SLV_SEL)
    ) u_decode (
        .i_sel     (w_dec_sel),
        .o_hit_vec (w_dec_vec),
        .o_hit     (w_dec_hit)
    );

    // Acks from slaves that are not currently requested are masked off here.
    assign w_ack_hit = |(s_ack & r_s_req);

    // One-hot read-data mux driven by the held request vector.
    always_comb begin
        w_sel_rdata = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_SLV; k++) begin
            w_sel_rdata = w_sel_rdata | (s_rdata[k*DATA_W +: DATA_W] & {DATA_W{r_s_req[k]}});
        end
    end

`ifdef SOC_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // An ack in the expiry cycle takes priority, so expiry requires no ack.
    assign w_tmo_expire = (r_state == ST_ACCESS) && !w_ack_hit &&
                          (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Count ACCESS cycles without an ack. The count is zero on every ACCESS entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if ((r_state == ST_ACCESS) && !w_ack_hit && !w_tmo_expire) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end else begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end
    end

    assign w_unused = ^{m_addr[ADDR_W-1:SEL_LSB+SEL_W]};
`else
    assign w_tmo_expire = 1'b0;
    assign w_unused     = ^{m_addr[ADDR_W-1:SEL_LSB+SEL_W], (TIMEOUT_CYC != 0)};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_req && w_dec_hit) begin
                    w_state_nxt = ST_ACCESS;
                end else if (m_req) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_ack_hit || w_tmo_expire) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs for each state.
    always_comb begin
        w_s_req_nxt   = r_s_req;
        w_s_we_nxt    = r_s_we;
        w_s_addr_nxt  = r_s_addr;
        w_s_wdata_nxt = r_s_wdata;
        w_rdata_nxt   = r_m_rdata;
        w_ready_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_req) begin
                    // Latch even on a miss. No slave is requested in that case.
                    w_s_we_nxt    = m_we;
                    w_s_addr_nxt  = m_addr[SEL_LSB-1:0];
                    w_s_wdata_nxt = m_wdata;
                    if (w_dec_hit) begin
                        w_s_req_nxt = w_dec_vec;
                    end else begin
                        w_s_req_nxt = {NUM_SLV{1'b0}};
                        w_ready_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        if (!m_we) begin
                            w_rdata_nxt = ERR_DATA;
                        end else begin
                            w_rdata_nxt = r_m_rdata;
                        end
                    end
                end else begin
                    w_s_req_nxt = {NUM_SLV{1'b0}};
                end
            end
            ST_ACCESS: begin
                if (w_ack_hit) begin
                    w_s_req_nxt = {NUM_SLV{1'b0}};
                    w_ready_nxt = 1'b1;
                    if (!r_s_we) begin
                        w_rdata_nxt = w_sel_rdata;
                    end else begin
                        w_rdata_nxt = r_m_rdata;
                    end
                end else if (w_tmo_expire) begin
                    w_s_req_nxt = {NUM_SLV{1'b0}};
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    if (!r_s_we) begin
                        w_rdata_nxt = ERR_DATA;
                    end else begin
                        w_rdata_nxt = r_m_rdata;
                    end
                end else begin
                    w_s_req_nxt = r_s_req;
                end
            end
            ST_RESP: w_s_req_nxt = {NUM_SLV{1'b0}};
            default: w_s_req_nxt = {NUM_SLV{1'b0}};
        endcase
    end

    // Output registers. A reset mid-access drops everything, including any response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_req   <= {NUM_SLV{1'b0}};
            r_s_we    <= 1'b0;
            r_s_addr  <= {SEL_LSB{1'b0}};
            r_s_wdata <= {DATA_W{1'b0}};
            r_m_rdata <= {DATA_W{1'b0}};
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
        end else begin
            r_s_req   <= w_s_req_nxt;
            r_s_we    <= w_s_we_nxt;
            r_s_addr  <= w_s_addr_nxt;
            r_s_wdata <= w_s_wdata_nxt;
            r_m_rdata <= w_rdata_nxt;
            r_m_ready <= w_ready_nxt;
            r_m_err   <= w_err_nxt;
        end
    end

    assign s_req   = r_s_req;
    assign s_we    = r_s_we;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign m_rdata = r_m_rdata;
    assign m_ready = r_m_ready;
    assign m_err   = r_m_err;

endmodule : soc_bus_fabric

// File: tb/tb_soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_soc_bus_fabric
// Self-checking bench for soc_bus_fabric with its default parameters. Each
// access runs through a transaction-level model. That model covers the
// address-map lookup, response latency from the slave ack delay, and the
// read-data history. The bench also plays the slaves, which ack with a
// programmable delay.
// -----------------------------------------------------------------------------
module tb_soc_bus_fabric;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [2:0]  s_req;
    logic        s_we;
    logic [8:0]  s_addr;
    logic [31:0] s_wdata;
    logic [95:0] s_rdata;
    logic [2:0]  s_ack;

    // Slave behaviour knobs.
    bit          ack_en;
    int          ack_delay;
    int          req_cnt;
    logic [2:0]  spur_mask;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rdata;
    int slv_code [3] = '{0, 4, 6};

    soc_bus_fabric u_dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    always #5 clk = ~clk;

    // Number of cycles the current slave request has already been held.
    always @(posedge clk) begin
        if (s_req == 3'b000) req_cnt <= 0;
        else                 req_cnt <= req_cnt + 1;
    end

    assign s_ack = (((ack_en && (req_cnt >= ack_delay)) ? s_req : 3'b000)) | spur_mask;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Address map lookup: first slave whose code matches bits [12:9], else -1.
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 3; i++) begin
            if (int'(a[12:9]) == slv_code[i]) return i;
        end
        return -1;
    endfunction

    // One complete access, entered and left on a falling edge.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input bit spur);
        int          k;
        int          cyc;
        int          req_cycles;
        logic [2:0]  oh;
        logic [2:0]  spur_bit;
        logic [31:0] sdata;
        k = ref_decode(addr);
        s_rdata   = {$urandom, $urandom, $urandom};
        ack_en    = 1'b1;
        ack_delay = delay;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
        @(negedge clk);
        m_req = 1'b0;
        if (k < 0) begin
            if (!we) exp_rdata = ERR_WORD;
            check_val("unm_ready", 32'(m_ready), 32'd1);
            check_val("unm_err",   32'(m_err),   32'd1);
            check_val("unm_sreq",  32'(s_req),   32'd0);
            check_val("unm_rdata", m_rdata,      exp_rdata);
        end else begin
            oh       = 3'b001 << k;
            spur_bit = (k == 0) ? 3'b010 : 3'b001;
            sdata    = s_rdata[k*32 +: 32];
            check_val("sreq",   32'(s_req),  32'(oh));
            check_val("saddr",  32'(s_addr), 32'(addr[8:0]));
            check_val("swe",    32'(s_we),   32'(we));
            check_val("swdata", s_wdata,     wdata);
            req_cycles = 0;
            cyc        = 1;
            while (!m_ready && cyc < 200) begin
                if (s_req == oh) req_cycles++;
                spur_mask = (spur && cyc == 2) ? spur_bit : 3'b000;
                @(negedge clk);
                cyc++;
            end
            spur_mask = 3'b000;
            if (!we) exp_rdata = sdata;
            check_val("latency",  32'(cyc),        32'(delay + 2));
            check_val("req_cyc",  32'(req_cycles), 32'(delay + 1));
            check_val("err",      32'(m_err),      32'd0);
            check_val("rdata",    m_rdata,         exp_rdata);
            check_val("sreq_off", 32'(s_req),      32'd0);
        end
        @(negedge clk);
        check_val("ready_pulse", 32'(m_ready), 32'd0);
    endtask

    initial begin
        int          cyc;
        bit          seen;
        logic [31:0] a;
        logic [31:0] d;
        int          dl;
        rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        s_rdata = 96'd0; ack_en = 1'b1; ack_delay = 0; spur_mask = 3'b000;
        exp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_sreq",  32'(s_req),   32'd0);
        check_val("rst_ready", 32'(m_ready), 32'd0);
        check_val("rst_err",   32'(m_err),   32'd0);
        check_val("rst_rdata", m_rdata,      32'd0);
        check_val("rst_saddr", 32'(s_addr),  32'd0);
        rst = 1'b0;

        // Directed accesses from the address map corners.
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
        check_val("rd_slv0", m_rdata, exp_rdata);
        run_txn(1'b1, 32'h0000_0804, 32'hA5A5_A5A5, 3, 1'b0);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 0, 1'b0);
        check_val("unm_rd_err_data", m_rdata, ERR_WORD);
        run_txn(1'b1, 32'h0000_0200, 32'h1111_2222, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0C08, 32'h0, 4, 1'b1);

        // A slave that never acks.
        s_rdata = {$urandom, $urandom, $urandom};
        ack_en = 1'b0;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0C00; m_wdata = 32'h0;
        @(negedge clk);
        m_req = 1'b0;
        check_val("noack_sreq", 32'(s_req), 32'b100);
`ifdef SOC_BUS_TIMEOUT_EN
        cyc = 1;
        while (!m_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        exp_rdata = ERR_WORD;
        check_val("tmo_latency", 32'(cyc), 32'(TMO + 1));
        check_val("tmo_err",     32'(m_err), 32'd1);
        check_val("tmo_rdata",   m_rdata,    exp_rdata);
`else
        seen = 1'b0;
        repeat (99) begin
            @(negedge clk);
            if (m_ready) seen = 1'b1;
        end
        check_val("noack_ready", 32'(seen), 32'd0);
        check_val("noack_hold",  32'(s_req), 32'b100);
        ack_en = 1'b1; ack_delay = 0;
        @(negedge clk);
        exp_rdata = s_rdata[64 +: 32];
        check_val("late_ready", 32'(m_ready), 32'd1);
        check_val("late_err",   32'(m_err),   32'd0);
        check_val("late_rdata", m_rdata,      exp_rdata);
        cyc = TMO;
`endif
        @(negedge clk);
        check_val("noack_pulse", 32'(m_ready), 32'd0);

        // Reset in the middle of an access.
        ack_en = 1'b0;
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0810; m_wdata = 32'h5555_0000;
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'd0;
        check_val("abort_sreq",  32'(s_req),   32'd0);
        check_val("abort_ready", 32'(m_ready), 32'd0);
        check_val("abort_rdata", m_rdata,      32'd0);
        check_val("abort_swd",   s_wdata,      32'd0);
        seen = 1'b0;
        ack_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m_ready || (s_req != 3'b000)) seen = 1'b1;
        end
        check_val("abort_quiet", 32'(seen), 32'd0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);

        // Randomised back-to-back traffic.
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[12:9] = 4'(slv_code[$urandom_range(0, 2)]);
            d  = $urandom;
            dl = $urandom_range(0, 6);
            run_txn(1'($urandom_range(0, 1)), a, d, dl, (dl >= 2) && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_soc_bus_fabric

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
Parametrised memory-mapped interconnect between the single-issue MIPS core's data port and NUM_SLV peripheral slaves (data memory, factorial accelerator, GPIO, and later blocks). It replaces the fixed combinational address decoder and 4:1 read-back mux with a registered request/acknowledge fabric. Slaves may take variable latency, unmapped or timed-out accesses report an error, and slave count and address map are parameters.

Parameters:
NUM_SLV, 3, number of slave channels (1..8)
DATA_W, 32, data width
ADDR_W, 32, master address width
SEL_LSB, 9, lowest address bit of the slave-select field
SEL_W, 4, width of the slave-select field m_addr[SEL_LSB+SEL_W-1:SEL_LSB]
SLV_SEL, {4'h6,4'h4,4'h0}, flat NUM_SLV*SEL_W select codes; slave k matches code k; lowest index wins on duplicates
TIMEOUT_CYC, 16, cycles in ACCESS before timeout (used only with the optional feature)
ERR_DATA, 32'hDEAD_BEEF, read data returned on any error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
m_req  in  1  master request, sampled only in IDLE
m_we  in  1  1=write, 0=read
m_addr  in  ADDR_W  byte address
m_wdata  in  DATA_W  write data
m_rdata  out  DATA_W  registered read data
m_ready  out  1  one-cycle response strobe
m_err  out  1  error flag, valid with m_ready
s_req  out  NUM_SLV  one-hot slave request, held until ack
s_we  out  1  latched write enable
s_addr  out  SEL_LSB  latched m_addr[SEL_LSB-1:0]
s_wdata  out  DATA_W  latched write data
s_rdata  in  NUM_SLV*DATA_W  flat slave read data; slave k at [k*DATA_W +: DATA_W]
s_ack  in  NUM_SLV  slave completion; may be combinational from s_req

Behaviour:
- Clock port is clk. Reset port is rst, synchronous and active-high. During reset: state=IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, timeout counter=0.
- States: IDLE, ACCESS, RESP.
- IDLE, m_req=1: latch m_we, m_addr low bits, m_wdata; decode.
  - Hit on slave k: next state ACCESS, s_req[k]=1 from the next cycle.
  - No hit: next state RESP with err=1; no slave is touched.
- ACCESS: s_req[k] is held.
  - s_ack[k]=1: drop s_req next cycle and go to RESP. On a read, m_rdata <= slave k data. On a write, m_rdata is unchanged.
  - s_ack from a non-selected slave is ignored.
- RESP: m_ready=1 for exactly one cycle, m_err valid. Then return to IDLE.
- Error read: m_rdata <= ERR_DATA. Error write: no slave sees it; m_rdata unchanged.
- Minimum latency with a combinational-ack slave: m_req in cycle 0, s_req in cycle 1, m_ready in cycle 2. Unmapped access: m_ready in cycle 1.
- m_req outside IDLE is ignored, and the master must hold it low until m_ready. A new m_req is accepted in the cycle after RESP (back-to-back, 3-cycle throughput).
- Reset asserted mid-access: abort immediately, all outputs go to reset values, and no m_ready is issued for the aborted access.
- s_addr, s_we and s_wdata stay stable from ACCESS entry until the next accepted request.

Optional Feature:
SOC_BUS_TIMEOUT_EN
- Defined: the counter clears on ACCESS entry and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYC, drop s_req, go to RESP with m_err=1, and on a read set m_rdata=ERR_DATA. An ack in the same cycle as expiry wins: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; m_err is asserted only for unmapped addresses.

Decomposition:
- Package soc_bus_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the default ERR_DATA constant.
- Sub-module soc_bus_decode: combinational select field -> one-hot hit vector plus hit flag, parametrised by NUM_SLV, SEL_W and SLV_SEL.

Test Plan:
- Read 0x0000_0010, slave 0 acks combinationally with data 0x1234_5678 -> s_req=3'b001 in cycle 1; m_ready=1, m_err=0, m_rdata=0x1234_5678 in cycle 2.
- Write 0x0000_0804 with data 0xA5A5_A5A5, slave 1 acks after 3 cycles -> s_req=3'b010 for 4 cycles, s_addr=0x004, s_wdata=0xA5A5_A5A5; m_ready 1 cycle after ack; m_rdata unchanged.
- Read 0x0000_0200 (select code 1, unmapped) -> no s_req; m_ready=1, m_err=1, m_rdata=0xDEAD_BEEF in cycle 1.
- Slave 2 access with a spurious s_ack[0] pulse before the real s_ack[2] -> spurious pulse ignored; completion only on s_ack[2].
- With SOC_BUS_TIMEOUT_EN and no ack on read 0x0000_0C00 -> s_req[2] drops after 16 cycles; m_err=1, m_rdata=0xDEAD_BEEF. Without the macro: still waiting at cycle 100.
- rst asserted while in ACCESS -> next cycle s_req=0, state IDLE, no m_ready; a fresh read then completes normally.
